// File: rtl/cnnpr_cache_pkg.sv
// Shared types and helpers for the CNN cache read path.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the line width default, the scheduler state enum and the requester-to-port map.
package cnnpr_cache_pkg;

    localparam int CACHE_WIDTH_DEF = 162;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    // Returns 1 when a requester index is served by port 13 (odd lanes).
    function automatic logic port_of(input int idx);
        return idx[0];
    endfunction

endpackage

// File: rtl/cache_read_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// Latency: combinational grant; the pointer advances on the clock edge after an enabled grant.
// Backpressure: grants only while en is high; with en low the pointer holds.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic         any
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0] NW = (PW+1)'(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   base, w;
    logic [N-1:0]  rot, pick;

    assign any = |req;

    always_comb begin
        base = {1'b0, ptr_q} + 1'b1;
        if (base >= NW) base = base - NW;
        // Rotate so the slot just after the last winner lands at bit 0.
        rot = N'({req, req} >> base);
        w   = base;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) w = base + (PW+1)'(i);
        end
        if (w >= NW) w = w - NW;
        pick  = N'(1) << w;
        gnt   = '0;
        ptr_d = ptr_q;
        if (en && any) begin
            gnt   = pick;
            ptr_d = w[PW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= PW'(N - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cache_read_scheduler.sv
// Frame read scheduler sharing cache ports 02/13 among NUM_REQ requesters (optional macro CACHE_SCHED_STALL_CNT_EN adds stall_cnt).
// Latency: grant and read_req in the issue cycle, rd_valid + rd_data two cycles later.
// Backpressure: an empty cache stalls only its own port; clk_en low freezes all state.
module cache_read_scheduler
    import cnnpr_cache_pkg::*;
#(
    parameter int CACHE_WIDTH = CACHE_WIDTH_DEF,
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   start,
    input  logic [CNT_W-1:0]       total_reads,
    output logic                   busy,
    output logic                   done,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   read_req02,
    output logic                   read_req13,
    input  logic                   empty02,
    input  logic                   empty13,
    input  logic [CACHE_WIDTH-1:0] cache_out02,
    input  logic [CACHE_WIDTH-1:0] cache_out13,
    output logic [NUM_REQ-1:0]     rd_valid,
    output logic [CACHE_WIDTH-1:0] rd_data02,
    output logic [CACHE_WIDTH-1:0] rd_data13
`ifdef CACHE_SCHED_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]       stall_cnt
`endif
);
    localparam int NP = NUM_REQ / 2;

    sched_state_e state_q, state_d;
    logic [CNT_W-1:0]       total_q, total_d, issued_q, issued_d, issued_inc;
    logic [NUM_REQ-1:0]     pend_q, vld_q;
    logic [CACHE_WIDTH-1:0] rd_data02_q, rd_data13_q;
    logic [NP-1:0]          req02, req13, g02, g13;
    logic                   any02, any13, ret02, ret13;
    logic                   run, elig02, elig13, en02, en13;

    always_comb begin
        req02 = '0;
        req13 = '0;
        gnt   = '0;
        ret02 = 1'b0;
        ret13 = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (port_of(i)) begin
                req13[i/2] = req[i];
                gnt[i]     = g13[i/2];
                ret13      = ret13 | pend_q[i];
            end else begin
                req02[i/2] = req[i];
                gnt[i]     = g02[i/2];
                ret02      = ret02 | pend_q[i];
            end
        end
    end

    assign any02 = |req02;
    assign any13 = |req13;
    assign run   = (state_q == RUN);

    // Port 13 sees port 02's issue first, so the last read of a frame goes to 02.
    assign elig02 = run && !empty02 && any02 && (issued_q < total_q);
    assign elig13 = run && !empty13 && any13 && ((issued_q + CNT_W'(elig02)) < total_q);
    assign en02   = elig02 && clk_en;
    assign en13   = elig13 && clk_en;

    assign read_req02 = en02;
    assign read_req13 = en13;
    assign issued_inc = issued_q + CNT_W'(en02) + CNT_W'(en13);

    rr_arbiter #(.N(NP)) u_arb02 (
        .clk(clk), .rst_n(rst_n), .req(req02), .en(en02), .gnt(g02), .any()
    );
    rr_arbiter #(.N(NP)) u_arb13 (
        .clk(clk), .rst_n(rst_n), .req(req13), .en(en13), .gnt(g13), .any()
    );

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        issued_d = issued_inc;
        case (state_q)
            IDLE: begin
                if (start) begin
                    total_d  = total_reads;
                    issued_d = '0;
                    state_d  = (total_reads == '0) ? DONE : RUN;
                end
            end
            RUN:     if (issued_inc == total_q) state_d = DRAIN;
            // The last return's strobe is visible in the cycle pend_q empties.
            DRAIN:   if (pend_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            total_q     <= '0;
            issued_q    <= '0;
            pend_q      <= '0;
            vld_q       <= '0;
            rd_data02_q <= '0;
            rd_data13_q <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            total_q  <= total_d;
            issued_q <= issued_d;
            pend_q   <= gnt;
            vld_q    <= pend_q;
            if (ret02) rd_data02_q <= cache_out02;
            if (ret13) rd_data13_q <= cache_out13;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE) && clk_en;
    assign rd_valid  = vld_q & {NUM_REQ{clk_en}};
    assign rd_data02 = rd_data02_q;
    assign rd_data13 = rd_data13_q;

`ifdef CACHE_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic             stall_hit;

    assign stall_hit = run && ((any02 && empty02) || (any13 && empty13));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (clk_en) begin
            if (state_q == IDLE && start)         stall_q <= '0;
            else if (stall_hit && stall_q != '1)  stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cache_read_scheduler.sv
// Directed bench for cache_read_scheduler; returns are checked by a scoreboard monitor.
module tb_cache_read_scheduler;
    localparam int CW    = 162;
    localparam int NR    = 4;
    localparam int CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst_n, clk_en, start;
    logic [CNT_W-1:0] total_reads;
    logic            busy, done, read_req02, read_req13, empty02, empty13;
    logic [NR-1:0]   req, gnt, rd_valid;
    logic [CW-1:0]   cache_out02, cache_out13, rd_data02, rd_data13;
`ifdef CACHE_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    cache_read_scheduler #(.CACHE_WIDTH(CW), .NUM_REQ(NR), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
        .total_reads(total_reads), .busy(busy), .done(done), .req(req), .gnt(gnt),
        .read_req02(read_req02), .read_req13(read_req13),
        .empty02(empty02), .empty13(empty13),
        .cache_out02(cache_out02), .cache_out13(cache_out13),
        .rd_valid(rd_valid), .rd_data02(rd_data02), .rd_data13(rd_data13)
`ifdef CACHE_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Cache model: output line is a function of the enabled-cycle count, frozen with clk_en.
    int cyc = 0;
    always @(posedge clk) if (clk_en === 1'b1) cyc <= cyc + 1;

    function automatic logic [CW-1:0] mk(input logic p13, input int c);
        logic [CW-1:0] v;
        v = '0;
        v[15:0] = c[15:0];
        v[16] = p13;
        v[CW-1 -: 8] = 8'hA5 ^ c[7:0];
        return v;
    endfunction

    assign cache_out02 = mk(1'b0, cyc);
    assign cache_out13 = mk(1'b1, cyc);

    typedef struct {
        int            idx;
        logic [CW-1:0] data;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int idx, input int c);
        exp_t e;
        e.idx  = idx;
        e.data = mk(idx[0], c);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rd_valid[i] === 1'b1) begin
                exp_t e;
                logic [CW-1:0] d;
                n_cmp++;
                d = i[0] ? rd_data13 : rd_data02;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_valid_unexpected: got strobe on requester %0d, expected none", i);
                end else begin
                    e = sb.pop_front();
                    if (e.idx != i || d !== e.data) begin
                        n_err++;
                        $display("FAIL rd_return: got req %0d data %0h expected req %0d data %0h",
                                 i, d, e.idx, e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; req = '0; empty02 = 1'b0; empty13 = 1'b0;
        total_reads = '0; clk_en = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_done(input string nm, input int exp_c);
        int  n;
        bit  seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            if (done === 1'b1) seen = 1'b1;
            else begin step(); #1; n++; end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s_done_timeout: got no done expected done within 60 cycles", nm);
        end else begin
            if (exp_c >= 0) chk({nm, "_done_cycle"}, CW'(cyc), CW'(exp_c));
            chk({nm, "_busy_at_done"}, CW'(busy), CW'(0));
            step(); #1;
            chk({nm, "_done_pulse"}, CW'(done), CW'(0));
        end
    endtask

    int s;
    logic [NR-1:0] g2 [4];
    logic [NR-1:0] g4;

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; req = '0; total_reads = '0;
        empty02 = 1'b0; empty13 = 1'b0;
        g2[0] = 4'b0011; g2[1] = 4'b1100; g2[2] = 4'b0011; g2[3] = 4'b1100;

        // Reset state
        do_reset();
        #1;
        chk("rst_busy", CW'(busy), CW'(0));
        chk("rst_done", CW'(done), CW'(0));
        chk("rst_gnt", CW'(gnt), CW'(0));
        chk("rst_rd_valid", CW'(rd_valid), CW'(0));
        chk("rst_rd_data02", rd_data02, '0);
        chk("rst_rd_data13", rd_data13, '0);
`ifdef CACHE_SCHED_STALL_CNT_EN
        chk("rst_stall_cnt", CW'(stall_cnt), CW'(0));
`endif

        // Single requester, 4 reads on port 02
        step(); req = 4'b0001; total_reads = 16'd4; start = 1'b1; #1; s = cyc;
        chk("t1_idle_gnt", CW'(gnt), CW'(0));
        for (int k = 0; k < 4; k++) begin
            step(); start = 1'b0; #1;
            chk("t1_gnt", CW'(gnt), CW'(4'b0001));
            chk("t1_rr02", CW'(read_req02), CW'(1));
            chk("t1_rr13", CW'(read_req13), CW'(0));
            chk("t1_busy", CW'(busy), CW'(1));
            push(0, cyc + 1);
        end
        step(); #1;
        chk("t1_no_extra", CW'(read_req02), CW'(0));
        wait_done("t1", s + 7);

        // All four requesting, 8 reads
        do_reset();
        step(); req = 4'b1111; total_reads = 16'd8; start = 1'b1; #1; s = cyc;
        for (int k = 0; k < 4; k++) begin
            step(); start = 1'b0; #1;
            chk("t2_gnt", CW'(gnt), CW'(g2[k]));
            chk("t2_rr13", CW'(read_req13), CW'(1));
            for (int i = 0; i < NR; i++) if (g2[k][i]) push(i, cyc + 1);
        end
        step(); #1;
        chk("t2_gnt_after", CW'(gnt), CW'(0));
        wait_done("t2", s + 7);

        // Odd total: last read goes to port 02 only
        do_reset();
        step(); req = 4'b1111; total_reads = 16'd3; start = 1'b1; #1; s = cyc;
        step(); start = 1'b0; #1;
        chk("t3_c1_gnt", CW'(gnt), CW'(4'b0011));
        push(0, cyc + 1); push(1, cyc + 1);
        step(); #1;
        chk("t3_c2_gnt", CW'(gnt), CW'(4'b0100));
        chk("t3_c2_rr13", CW'(read_req13), CW'(0));
        push(2, cyc + 1);
        step(); #1;
        chk("t3_c3_gnt", CW'(gnt), CW'(0));
        wait_done("t3", s + 5);

        // Port 13 empty for 5 cycles; port 02 keeps going; start while busy ignored
        do_reset();
        step(); req = 4'b0011; total_reads = 16'd10; empty13 = 1'b1; start = 1'b1; #1; s = cyc;
        for (int k = 0; k < 8; k++) begin
            step();
            start = (k == 2);
            total_reads = (k == 2) ? 16'd1 : 16'd10;
            if (k == 5) empty13 = 1'b0;
            #1;
            g4 = (k == 5 || k == 6) ? 4'b0011 : 4'b0001;
            chk("t4_gnt", CW'(gnt), CW'(g4));
            chk("t4_rr13", CW'(read_req13), CW'(k == 5 || k == 6));
            for (int i = 0; i < NR; i++) if (g4[i]) push(i, cyc + 1);
        end
        start = 1'b0;
        step(); #1;
        chk("t4_gnt_after", CW'(gnt), CW'(0));
        wait_done("t4", s + 11);
`ifdef CACHE_SCHED_STALL_CNT_EN
        chk("t4_stall_cnt", CW'(stall_cnt), CW'(5));
`endif

        // clk_en drops after a grant and again while the return is held
        do_reset();
        step(); req = 4'b0001; total_reads = 16'd1; start = 1'b1; #1; s = cyc;
        step(); start = 1'b0; #1;
        chk("t5_gnt", CW'(gnt), CW'(4'b0001));
        push(0, cyc + 1);
        for (int k = 0; k < 3; k++) begin
            step(); clk_en = 1'b0; #1;
            chk("t5_frozen1_valid", CW'(rd_valid), CW'(0));
        end
        step(); clk_en = 1'b1; #1;
        chk("t5_capture_valid", CW'(rd_valid), CW'(0));
        for (int k = 0; k < 2; k++) begin
            step(); clk_en = 1'b0; #1;
            chk("t5_gated_valid", CW'(rd_valid), CW'(0));
        end
        step(); clk_en = 1'b1; #1;
        chk("t5_pulse", CW'(rd_valid), CW'(4'b0001));
        chk("t5_data", rd_data02, mk(1'b0, s + 2));
        step(); #1;
        chk("t5_no_dup", CW'(rd_valid), CW'(0));
        wait_done("t5", -1);

        // Reset mid-RUN with returns in flight, then a clean frame
        do_reset();
        step(); req = 4'b1111; total_reads = 16'd20; start = 1'b1; #1;
        step(); start = 1'b0; #1;
        chk("t6_c1_gnt", CW'(gnt), CW'(4'b0011));
        step(); #1;
        chk("t6_c2_gnt", CW'(gnt), CW'(4'b1100));
        step(); #1;
        chk("t6_c3_valid", CW'(rd_valid), CW'(4'b0011));
        #1; rst_n = 1'b0; #1;
        chk("t6_rst_gnt", CW'(gnt), CW'(0));
        chk("t6_rst_rr02", CW'(read_req02), CW'(0));
        chk("t6_rst_busy", CW'(busy), CW'(0));
        chk("t6_rst_valid", CW'(rd_valid), CW'(0));
        chk("t6_rst_data02", rd_data02, '0);
        step(); rst_n = 1'b1;
        step(); req = 4'b0011; total_reads = 16'd2; start = 1'b1; #1; s = cyc;
        step(); start = 1'b0; #1;
        chk("t6_clean_gnt", CW'(gnt), CW'(4'b0011));
        push(0, cyc + 1); push(1, cyc + 1);
        step(); #1;
        chk("t6_clean_after", CW'(gnt), CW'(0));
        wait_done("t6", s + 4);

        // Zero-length frame
        step(); req = 4'b0001; total_reads = 16'd0; start = 1'b1; #1;
        step(); start = 1'b0; #1;
        chk("t7_gnt", CW'(gnt), CW'(0));
        chk("t7_done", CW'(done), CW'(1));

        repeat (4) step();
        chk("sb_drained", CW'(sb.size()), CW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_read_scheduler.md
# cache_read_scheduler

Shares the two cache read ports of `mem_controller` (even-lane port `02`, odd-lane port `13`) among `NUM_REQ` PE-group requesters in the CNN datapath. It runs one frame of a programmed number of reads: round-robin arbitration per port, never issuing into an empty cache, and steering each returned cache line back to the requester that was granted it. It sits between the PE array and `mem_controller`, driving `read_req02`/`read_req13`.

## Interface
- `CACHE_WIDTH`, 162, cache line width; must match `mem_controller`.
- `NUM_REQ`, 4, requester count; even, ≥2. Even indices use port 02, odd indices use port 13.
- `CNT_W`, 16, width of the frame read counter and the stall counter.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  global clock enable; when low, all state holds.
- `start`  in  1  one-cycle frame start pulse.
- `total_reads`  in  CNT_W  reads in the frame across both ports; sampled on `start`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of frame.
- `req`  in  NUM_REQ  level request per requester.
- `gnt`  out  NUM_REQ  one-hot per port; pulses in the cycle the read is issued.
- `read_req02` / `read_req13`  out  1  read strobes to `mem_controller`.
- `empty02` / `empty13`  in  1  cache empty flags.
- `cache_out02` / `cache_out13`  in  CACHE_WIDTH  cache data; valid the cycle after `read_req`.
- `rd_valid`  out  NUM_REQ  one-cycle return strobe to the granted requester.
- `rd_data02` / `rd_data13`  out  CACHE_WIDTH  registered return data.
- `stall_cnt`  out  CNT_W  present only with the macro (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start`, latch `total_reads` and clear `issued`.
  - If `total_reads`=0, go to DONE; otherwise go to RUN.
- RUN, per port:
  - The port is eligible when `!emptyXX`, some mapped `req` bit is high, and `issued` < latched total.
  - The round-robin winner is the first requesting index after the last-granted index of that port, wrapping.
  - An eligible port asserts `read_reqXX` and `gnt[winner]`, updates its pointer, and increments `issued`.
- Both ports eligible with one read remaining: port 02 issues, port 13 does not.
- When `issued` reaches the total, go to DRAIN.
- DRAIN: wait until no return is in flight, then go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `start` while `busy`: ignored.
- Requests outside RUN: ignored, no `gnt`.
- `read_reqXX` and `gnt` are combinational from registered state and inputs, and are gated by `clk_en`.

## Timing
- Issue cycle N: `read_reqXX`=1 and `gnt[i]`=1.
- Cycle N+1: `cache_outXX` is registered into `rd_dataXX` and a valid flag is set for index i.
- Cycle N+2: `rd_valid[i]`=1 with `rd_dataXX` stable. Grant-to-data latency is 2 cycles.
- Back-to-back issues on the same port every cycle give one return per cycle.
- `rd_valid` = valid register AND `clk_en`. Low `clk_en` freezes the pipeline and causes no duplicate delivery.
- Reset values (asynchronous): state IDLE; `busy`, `done`, `gnt`, `read_req*`, `rd_valid` = 0; `rd_data*` = 0; counters = 0; both RR pointers select the port's highest index, so index 0/1 wins first.
- Reset mid-frame aborts immediately: in-flight returns are discarded and `done` is not pulsed.
- An empty cache stalls only its own port; the other port continues.

## Configuration
- `CACHE_SCHED_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - Increments, saturating, in each `clk_en` cycle of RUN where some port has a pending mapped request but its `emptyXX`=1.
  - Cleared on accepted `start`.
- Not defined: the port and its counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `cnnpr_cache_pkg`:
  - `CACHE_WIDTH` default.
  - Scheduler state enum `{IDLE, RUN, DRAIN, DONE}`.
  - Port-mapping helper (index → port).
- Sub-module `rr_arbiter`:
  - Parameter `N` = `NUM_REQ/2`.
  - Inputs: `req[N]`, `en`. Outputs: one-hot `gnt[N]`, `any`.
  - Internal last-grant pointer.
  - Instantiated twice, once per port.

## Test plan
- `total_reads`=4, `req`=4'b0001 held, `empty02`=0 → `read_req02` for 4 consecutive cycles, `rd_valid[0]` on cycles N+2…N+5, `done` one cycle after the last `rd_valid`, `read_req13` never set.
- `req`=4'b1111, `total_reads`=8, neither port empty → `gnt` sequence 0,2,0,2 on port 02 and 1,3,1,3 on port 13; 4 cycles to issue all 8 reads.
- `total_reads`=3, both ports eligible → cycle 1 issues 2 reads, cycle 2 issues only the port 02 read; `issued`=3, no 4th `read_req`.
- `empty13`=1 for 5 cycles with `req[1]` high → no `read_req13` during those cycles while port 02 proceeds; with the macro, `stall_cnt`=5.
- Drop `clk_en` for 3 cycles at cycle N+1 after a grant → `rd_valid` held low, then exactly one `rd_valid` pulse after `clk_en` returns, with the same data.
- Assert `rst_n` low mid-RUN with returns in flight → all outputs 0 asynchronously; a new `start` after reset runs a clean frame with index 0 granted first.
